alien_bomb: RTL and testbench
=============================

ALIEN_BOMB -- requirements
Module: alien_bomb

Interface
REQ-001 Parameter COOLDOWN, default 6: enable ticks between the end of one bomb and the next drop (range 0..15).
REQ-002 Parameter LFSR_SEED, default 8'hA5: reset value of the drop-column LFSR (nonzero).
REQ-003 clk_12MHz  in  1  sole clock; all state on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  game step tick; motion, spawn and collision act only on cycles with enable=1.
REQ-006 game_run  in  1  play in progress; low forbids spawning and kills a flying bomb.
REQ-007 formation_alive  in  1  at least one alien remains.
REQ-008 formation_x  in  5  leftmost column of the 8-column alien formation.
REQ-009 formation_y  in  4  bottom row of the alien formation.
REQ-010 ship_x  in  5  player ship column; ship occupies row 14.
REQ-011 bullet_flying, bullet_x[4:0], bullet_y[3:0]  in  player bullet state.
REQ-012 bomb_flying  out  1  bomb on screen.
REQ-013 bomb_x  out  5 / bomb_y  out  4  bomb position; row 0 is the top, y increases downward.
REQ-014 ship_hit  out  1  one-clock pulse: the bomb struck the ship.
REQ-015 bomb_shot  out  1  one-clock pulse: the bomb was destroyed by the player bullet; integration ORs it into the bullet's hit input.

Function
REQ-016 States: COOL (no bomb, cool_cnt counting) and FALL (bomb_flying=1).
REQ-017 COOL, enable=1, cool_cnt>0: cool_cnt decrements by 1.
REQ-018 COOL, enable=1, cool_cnt=0, game_run=1, formation_alive=1: go to FALL; bomb_x = (formation_x + lfsr[2:0]) mod 32; bomb_y = formation_y+1, saturating at 15.
REQ-019 COOL, cool_cnt=0, spawn blocked: hold at 0 and spawn on the first enable tick on which the conditions hold.
REQ-020 FALL, enable=1, priority order evaluated on current register values:
  (a) bullet_flying=1, bullet_x=bomb_x, and bullet_y in {bomb_y, bomb_y+1} -> bomb_shot=1, clear;
  (b) else bomb_y=14 and bomb_x=ship_x -> ship_hit=1, clear;
  (c) else bomb_y=15 -> clear with no pulse;
  (d) else bomb_y increments by 1.
REQ-021 Clear means: bomb_flying=0, bomb_x=0, bomb_y=0, cool_cnt=COOLDOWN, state COOL.
REQ-022 game_run=0 in FALL clears on that clock regardless of enable; there is no pulse.
REQ-023 A spawn and a collision check never occur on the same tick; a new bomb is checked first on the following tick.
REQ-024 ship_hit and bomb_shot are registered, are never high together, and are low on every cycle except the flagged enable cycle.
REQ-025 With enable=0, all outputs hold, except as stated in REQ-022; the pulses are 0.
REQ-026 LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1; it advances every clock regardless of enable.
REQ-027 The formation_x addition wraps modulo 32; there is no clamping.

Reset
REQ-028 Reset drives bomb_flying=0, bomb_x=0, bomb_y=0, ship_hit=0, bomb_shot=0, state=COOL, cool_cnt=COOLDOWN, lfsr=LFSR_SEED.
REQ-029 Reset asserted mid-flight clears the bomb immediately without a pulse; the first spawn after release needs COOLDOWN+1 enable ticks.

Structure
REQ-030 The shared game package holds SHIP_ROW=14, BOTTOM_ROW=15, GRID_COLS=32, FORMATION_COLS=8 and the state enum.
REQ-031 The LFSR is a separate sub-module, lfsr8, with an enable and a seed parameter, so the alien march logic can reuse it.

Verification
REQ-032 Reset; game_run=1, formation_alive=1, formation_x=4, formation_y=5, COOLDOWN=6 -> spawn on enable tick 7 with bomb_y=6 and bomb_x in 4..11.
REQ-033 Bomb at (10,13), ship_x=10, no bullet -> next tick bomb_y=14; following tick ship_hit pulses exactly 1 clock and bomb_y=0, bomb_flying=0.
REQ-034 Bomb at (7,8), bullet at (7,9), bullet_flying=1, ship_x=7 -> bomb_shot pulse, no ship_hit; a repeat with the bullet at (7,8) gives the same result.
REQ-035 Bomb at (3,14), ship_x=9 -> next tick y=15; following tick clear with no pulses.
REQ-036 formation_x=28, lfsr[2:0]=6 -> bomb_x=2 (wrap); formation_y=15 -> bomb_y=15.
REQ-037 game_run deasserted with the bomb at y=9 and enable=0 -> bomb_flying=0 next clock, no pulses; reset pulsed mid-flight -> outputs zero asynchronously.

Source files
------------

// File: rtl/alien_bomb_pkg.sv
// Shared game package: playfield geometry, field widths and the bomb FSM state type.
// Pure declarations; no logic and no latency.
// No flow control; consumers import the constants they need.
package alien_bomb_pkg;

  // Playfield geometry. Row 0 is the top of the screen and y grows downward.
  localparam int GRID_COLS      = 32;
  localparam int FORMATION_COLS = 8;

  // Field widths derived from the geometry.
  localparam int COL_W = $clog2(GRID_COLS);       // 5-bit column
  localparam int ROW_W = 4;                       // 16 rows
  localparam int CNT_W = 4;                       // cooldown range 0..15
  localparam int OFS_W = $clog2(FORMATION_COLS);  // drop offset inside formation

  localparam logic [ROW_W-1:0] SHIP_ROW   = 4'd14;
  localparam logic [ROW_W-1:0] BOTTOM_ROW = 4'd15;

  // COOL: no bomb on screen, cooldown counting down.
  // FALL: bomb on screen, moving one row per enable tick.
  typedef enum logic [0:0] {
    ST_COOL = 1'b0,
    ST_FALL = 1'b1
  } bomb_state_t;

  // Spawn row is one below the formation, pinned to the bottom row.
  function automatic logic [ROW_W-1:0] spawn_row(input logic [ROW_W-1:0] form_y);
    spawn_row = (form_y == BOTTOM_ROW) ? BOTTOM_ROW : form_y + 4'd1;
  endfunction

endpackage

// File: rtl/alien_bomb_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, shifting left.
// Latency: new value one clock after each cycle with i_en high.
// No backpressure; i_en simply gates the advance.
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-high reset, loads SEED
//   i_en     advance the sequence this clock
//   o_rnd    low OUT_W bits of the current state
module lfsr8 #(
  parameter logic [7:0] SEED  = 8'hA5,  // must be nonzero or the register locks up
  parameter int         OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [OUT_W-1:0] o_rnd
);

  logic [7:0] r_state;
  logic       w_fb;

  // Taps 8,6,5,4 map to bits 7,5,4,3 when shifting toward the MSB.
  assign w_fb = r_state[7] ^ r_state[5] ^ r_state[4] ^ r_state[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= {r_state[6:0], w_fb};
    end
  end

  assign o_rnd = r_state[OUT_W-1:0];

endmodule

// File: rtl/alien_bomb.sv
// alien_bomb: single alien bomb - cooldown, drop from a pseudo-random formation column,
// fall, and collision against the player bullet and the ship.
// Latency: all outputs registered; a decision on enable tick N is visible after that edge.
// No backpressure; the block advances only on enable ticks (game_run low acts at once).
//
// Ports:
//   clk_12MHz, reset               clock and asynchronous active-high reset
//   enable                         game step tick
//   game_run, formation_alive      spawn permission; game_run low also kills the bomb
//   formation_x/_y                 formation leftmost column / bottom row
//   ship_x                         ship column (ship sits on SHIP_ROW)
//   bullet_flying/_x/_y            player bullet
//   bomb_flying/_x/_y              bomb state
//   ship_hit, bomb_shot            one-clock collision pulses
module alien_bomb
  import alien_bomb_pkg::*;
#(
  parameter int unsigned COOLDOWN  = 6,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic             clk_12MHz,
  input  logic             reset,
  input  logic             enable,
  input  logic             game_run,
  input  logic             formation_alive,
  input  logic [COL_W-1:0] formation_x,
  input  logic [ROW_W-1:0] formation_y,
  input  logic [COL_W-1:0] ship_x,
  input  logic             bullet_flying,
  input  logic [COL_W-1:0] bullet_x,
  input  logic [ROW_W-1:0] bullet_y,
  output logic             bomb_flying,
  output logic [COL_W-1:0] bomb_x,
  output logic [ROW_W-1:0] bomb_y,
  output logic             ship_hit,
  output logic             bomb_shot
);

  localparam logic [CNT_W-1:0] COOL_INIT = CNT_W'(COOLDOWN);

  bomb_state_t      r_state;
  logic [COL_W-1:0] r_x;
  logic [ROW_W-1:0] r_y;
  logic [CNT_W-1:0] r_cool;
  logic             r_hit;
  logic             r_shot;

  bomb_state_t      w_state_nxt;
  logic [COL_W-1:0] w_x_nxt;
  logic [ROW_W-1:0] w_y_nxt;
  logic [CNT_W-1:0] w_cool_nxt;
  logic             w_hit_nxt;
  logic             w_shot_nxt;
  logic             w_clear;

  logic [OFS_W-1:0] w_drop_ofs;
  logic [COL_W-1:0] w_spawn_x;
  logic             w_bullet_on_bomb;

  // Free-running drop-column generator; it steps every clock so the drop
  // column depends on wall-clock timing, not just on the number of ticks.
  lfsr8 #(
    .SEED  (LFSR_SEED),
    .OUT_W (OFS_W)
  ) u_lfsr (
    .clk   (clk_12MHz),
    .rst   (reset),
    .i_en  (1'b1),
    .o_rnd (w_drop_ofs)
  );

  // Column addition wraps around the playfield edge on purpose.
  assign w_spawn_x = formation_x + COL_W'(w_drop_ofs);

  // The bullet travels upward, so it may sit on the bomb's row or the row just
  // below it. Compared one bit wider so a bomb on the bottom row never matches
  // a bullet wrapped back to row 0.
  assign w_bullet_on_bomb = bullet_flying && (bullet_x == r_x) &&
                            (({1'b0, bullet_y} == {1'b0, r_y}) ||
                             ({1'b0, bullet_y} == ({1'b0, r_y} + 5'd1)));

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_cool_nxt  = r_cool;
    w_hit_nxt   = 1'b0;
    w_shot_nxt  = 1'b0;
    w_clear     = 1'b0;

    case (r_state)
      ST_COOL: begin
        if (enable) begin
          if (r_cool != '0) begin
            w_cool_nxt = r_cool - 1'b1;
          end else if (game_run && formation_alive) begin
            // Spawn tick: no collision check until the next tick.
            w_state_nxt = ST_FALL;
            w_x_nxt     = w_spawn_x;
            w_y_nxt     = spawn_row(formation_y);
          end
        end
      end

      ST_FALL: begin
        if (!game_run) begin
          // Game stopped: drop the bomb silently, even between ticks.
          w_clear = 1'b1;
        end else if (enable) begin
          if (w_bullet_on_bomb) begin
            w_shot_nxt = 1'b1;
            w_clear    = 1'b1;
          end else if ((r_y == SHIP_ROW) && (r_x == ship_x)) begin
            w_hit_nxt = 1'b1;
            w_clear   = 1'b1;
          end else if (r_y == BOTTOM_ROW) begin
            w_clear = 1'b1;
          end else begin
            w_y_nxt = r_y + 1'b1;
          end
        end
      end

      default: w_clear = 1'b1;
    endcase

    if (w_clear) begin
      w_state_nxt = ST_COOL;
      w_x_nxt     = '0;
      w_y_nxt     = '0;
      w_cool_nxt  = COOL_INIT;
    end
  end

  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      r_state <= ST_COOL;
      r_x     <= '0;
      r_y     <= '0;
      r_cool  <= COOL_INIT;
      r_hit   <= 1'b0;
      r_shot  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_cool  <= w_cool_nxt;
      r_hit   <= w_hit_nxt;
      r_shot  <= w_shot_nxt;
    end
  end

  assign bomb_flying = (r_state == ST_FALL);
  assign bomb_x      = r_x;
  assign bomb_y      = r_y;
  assign ship_hit    = r_hit;
  assign bomb_shot   = r_shot;

endmodule

// File: tb/tb_alien_bomb.sv
module tb_alien_bomb;

  localparam int COOLDOWN = 6;

  logic       clk_12MHz = 1'b0;
  logic       reset;
  logic       enable;
  logic       game_run;
  logic       formation_alive;
  logic [4:0] formation_x;
  logic [3:0] formation_y;
  logic [4:0] ship_x;
  logic       bullet_flying;
  logic [4:0] bullet_x;
  logic [3:0] bullet_y;
  logic       bomb_flying;
  logic [4:0] bomb_x;
  logic [3:0] bomb_y;
  logic       ship_hit;
  logic       bomb_shot;

  alien_bomb #(.COOLDOWN(COOLDOWN), .LFSR_SEED(8'hA5)) dut (
    .clk_12MHz       (clk_12MHz),
    .reset           (reset),
    .enable          (enable),
    .game_run        (game_run),
    .formation_alive (formation_alive),
    .formation_x     (formation_x),
    .formation_y     (formation_y),
    .ship_x          (ship_x),
    .bullet_flying   (bullet_flying),
    .bullet_x        (bullet_x),
    .bullet_y        (bullet_y),
    .bomb_flying     (bomb_flying),
    .bomb_x          (bomb_x),
    .bomb_y          (bomb_y),
    .ship_hit        (ship_hit),
    .bomb_shot       (bomb_shot)
  );

  always #5 clk_12MHz = ~clk_12MHz;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bomb as plain integers, plus the drop-column sequence.
  int m_fly, m_x, m_y, m_cool, m_lfsr, e_hit, e_shot;

  function automatic int lfsr_next(input int v);
    int fb;
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return ((v << 1) | fb) & 255;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fly = 0; m_x = 0; m_y = 0; m_cool = COOLDOWN; m_lfsr = 8'hA5;
    e_hit = 0; e_shot = 0;
  endtask

  task automatic model_clear();
    m_fly = 0; m_x = 0; m_y = 0; m_cool = COOLDOWN;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".fly"},  32'(bomb_flying), 32'(m_fly));
    check({tag, ".x"},    32'(bomb_x),      32'(m_x));
    check({tag, ".y"},    32'(bomb_y),      32'(m_y));
    check({tag, ".hit"},  32'(ship_hit),    32'(e_hit));
    check({tag, ".shot"}, 32'(bomb_shot),   32'(e_shot));
  endtask

  // Advance one clock: predict from the game rules, then compare after the edge.
  task automatic tick(input string tag);
    e_hit = 0; e_shot = 0;
    if (m_fly != 0) begin
      if (!game_run) begin
        model_clear();
      end else if (enable) begin
        if (bullet_flying && int'(bullet_x) == m_x &&
            (int'(bullet_y) == m_y || int'(bullet_y) == m_y + 1)) begin
          e_shot = 1; model_clear();
        end else if (m_y == 14 && m_x == int'(ship_x)) begin
          e_hit = 1; model_clear();
        end else if (m_y == 15) begin
          model_clear();
        end else begin
          m_y++;
        end
      end
    end else if (enable) begin
      if (m_cool > 0) begin
        m_cool--;
      end else if (game_run && formation_alive) begin
        m_fly = 1;
        m_x = (int'(formation_x) + (m_lfsr % 8)) % 32;
        m_y = int'(formation_y) + 1;
        if (m_y > 15) m_y = 15;
      end
    end
    m_lfsr = lfsr_next(m_lfsr);
    @(posedge clk_12MHz); #1;
    compare_all(tag);
  endtask

  // Wait for the bomb to be gone and cooldown expired, then drop it at (tx,ty).
  task automatic spawn_at(input int tx, input int ty);
    game_run = 1; formation_alive = 1; enable = 1; bullet_flying = 0; ship_x = 5'd31;
    formation_y = 4'd0;
    for (int k = 0; k < 40 && (m_fly != 0 || m_cool != 0); k++) tick("spawn_wait");
    check("spawn_ready", 32'(m_fly + m_cool), 32'd0);
    formation_x = 5'((tx - (m_lfsr % 8)) & 31);
    formation_y = 4'(ty - 1);
    tick("spawn");
    check("spawn_x", 32'(bomb_x), 32'(tx));
    check("spawn_y", 32'(bomb_y), 32'(ty));
    enable = 0;
  endtask

  initial begin
    reset = 1; enable = 0; game_run = 0; formation_alive = 0;
    formation_x = '0; formation_y = '0; ship_x = '0;
    bullet_flying = 0; bullet_x = '0; bullet_y = '0;
    model_reset();
    repeat (2) @(posedge clk_12MHz);
    #1;
    compare_all("reset");
    reset = 0;

    // First drop: six ticks of cooldown, spawn on the seventh.
    game_run = 1; formation_alive = 1; formation_x = 5'd4; formation_y = 4'd5; enable = 1;
    for (int i = 0; i < 6; i++) tick("cooldown");
    check("cool_no_bomb", 32'(bomb_flying), 32'd0);
    tick("first_spawn");
    check("first_spawn_fly", 32'(bomb_flying), 32'd1);
    check("first_spawn_y", 32'(bomb_y), 32'd6);
    check("first_spawn_x_range", 32'(bomb_x >= 5'd4 && bomb_x <= 5'd11), 32'd1);

    // Ship strike.
    spawn_at(10, 13);
    ship_x = 5'd10; enable = 1;
    tick("hit_step");
    check("hit_step_y", 32'(bomb_y), 32'd14);
    tick("hit");
    check("hit_pulse", 32'(ship_hit), 32'd1);
    check("hit_clear_y", 32'(bomb_y), 32'd0);
    check("hit_clear_fly", 32'(bomb_flying), 32'd0);
    enable = 0;
    tick("hit_after");
    check("hit_one_clock", 32'(ship_hit), 32'd0);

    // Bullet one row below, then on the same row; ship underneath is ignored.
    for (int r = 9; r >= 8; r--) begin
      spawn_at(7, 8);
      bullet_flying = 1; bullet_x = 5'd7; bullet_y = 4'(r); ship_x = 5'd7; enable = 1;
      tick("shot");
      check("shot_pulse", 32'(bomb_shot), 32'd1);
      check("shot_no_hit", 32'(ship_hit), 32'd0);
      check("shot_clear", 32'(bomb_flying), 32'd0);
      bullet_flying = 0;
    end

    // Miss: falls past the ship and leaves the screen silently.
    spawn_at(3, 14);
    ship_x = 5'd9; enable = 1;
    tick("miss_step");
    check("miss_y15", 32'(bomb_y), 32'd15);
    tick("miss_clear");
    check("miss_fly", 32'(bomb_flying), 32'd0);
    check("miss_no_pulse", 32'(ship_hit | bomb_shot), 32'd0);

    // Column wrap and row saturation.
    game_run = 0; enable = 1;
    for (int k = 0; k < 40 && (m_fly != 0 || m_cool != 0); k++) tick("wrap_wait");
    enable = 0; game_run = 1; formation_alive = 1;
    for (int k = 0; k < 64 && (m_lfsr % 8) != 6; k++) tick("wrap_lfsr");
    check("wrap_lfsr_found", 32'(m_lfsr % 8), 32'd6);
    formation_x = 5'd28; formation_y = 4'd15; enable = 1;
    tick("wrap_spawn");
    check("wrap_x", 32'(bomb_x), 32'd2);
    check("wrap_y", 32'(bomb_y), 32'd15);
    check("wrap_fly", 32'(bomb_flying), 32'd1);

    // game_run drop between ticks.
    spawn_at(5, 9);
    enable = 0; game_run = 0;
    tick("kill");
    check("kill_fly", 32'(bomb_flying), 32'd0);
    check("kill_no_pulse", 32'(ship_hit | bomb_shot), 32'd0);

    // Reset mid-flight clears without waiting for a clock.
    spawn_at(6, 4);
    reset = 1;
    #1;
    check("areset_fly", 32'(bomb_flying), 32'd0);
    check("areset_x", 32'(bomb_x), 32'd0);
    check("areset_y", 32'(bomb_y), 32'd0);
    check("areset_pulses", 32'(ship_hit | bomb_shot), 32'd0);
    @(posedge clk_12MHz); #1;
    reset = 0;
    model_reset();
    game_run = 1; formation_alive = 1; formation_x = 5'd12; formation_y = 4'd2; enable = 1;
    for (int i = 0; i < COOLDOWN; i++) tick("post_reset_cool");
    check("post_reset_no_bomb", 32'(bomb_flying), 32'd0);
    tick("post_reset_spawn");
    check("post_reset_spawn", 32'(bomb_flying), 32'd1);

    // Randomized play against the model.
    for (int i = 0; i < 600; i++) begin
      enable          = ($urandom_range(0, 3) != 0);
      game_run        = ($urandom_range(0, 15) != 0);
      formation_alive = ($urandom_range(0, 7) != 0);
      formation_x     = 5'($urandom_range(0, 31));
      formation_y     = 4'($urandom_range(0, 15));
      ship_x          = ($urandom_range(0, 1) != 0) ? 5'(m_x) : 5'($urandom_range(0, 31));
      bullet_flying   = ($urandom_range(0, 2) == 0);
      bullet_x        = ($urandom_range(0, 1) != 0) ? 5'(m_x) : 5'($urandom_range(0, 31));
      bullet_y        = ($urandom_range(0, 1) != 0) ? 4'(m_y + $urandom_range(0, 2))
                                                    : 4'($urandom_range(0, 15));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
